// File: rtl/plab5_mcore_debug_responder.sv
// Core-side debug command responder: decodes {type, index} commands, samples the
// addressed core, and returns 32-bit responses in order through a small FIFO.
module plab5_mcore_debug_responder #(
   parameter int p_cmd_nbits   = 6,
   parameter int p_msg_nbits   = 32,
   parameter int p_num_cores   = 2,
   parameter int p_num_entries = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_val,
   output logic                     req_rdy,
   input  logic [p_cmd_nbits-1:0]   req_cmd,
   output logic                     resp_val,
   input  logic                     resp_rdy,
   output logic [p_msg_nbits-1:0]   resp_msg,
   input  logic [p_num_cores*32-1:0] core_insts,
   output logic [7:0]               cmd_count,
   output logic [7:0]               err_count
);

   localparam int              PTR_W    = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
   localparam int              TYPE_W   = p_cmd_nbits - 3;
   localparam logic [PTR_W:0]  DEPTH    = (PTR_W+1)'(p_num_entries);
   localparam logic [3:0]      NCORES   = 4'(p_num_cores);
   localparam logic [7:0]      NCORES_B = 8'(p_num_cores);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [TYPE_W-1:0]    cmd_type;
   logic [2:0]           cmd_idx;
   logic [31:0]          inst_sel;
   logic [31:0]          msg_p0;
   logic                 err_p0;
   logic                 req_go;
   logic                 resp_go;
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W:0]       occ;
   logic [PTR_W:0]       occ_next;
   logic [p_msg_nbits-1:0] fifo_mem [p_num_entries];

   assign cmd_type = req_cmd[p_cmd_nbits-1:3];
   assign cmd_idx  = req_cmd[2:0];
   assign req_go   = req_val & req_rdy;
   assign resp_go  = resp_val & resp_rdy;

   // Decode stage: message is formed from the command and core state in the accept cycle
   always_comb begin
      inst_sel = '0;
      for (int i = 0; i < p_num_cores; i++) begin
         if (cmd_idx == 3'(i)) inst_sel = core_insts[i*32 +: 32];
      end
      err_p0 = 1'b0;
      msg_p0 = '0;
      if ({1'b0, cmd_idx} >= NCORES)
         err_p0 = 1'b1;
      else if (cmd_type == '0)
         msg_p0 = {8'h00, NCORES_B, 8'h00, 5'b0, cmd_idx};
      else if (cmd_type == TYPE_W'(1))
         msg_p0 = inst_sel;
      else
         err_p0 = 1'b1;
      if (err_p0) msg_p0 = {16'hDEAD, 16'(req_cmd)};
   end

   always_comb begin
      occ_next = occ;
      if (req_go && !resp_go)
         occ_next = occ + 1'b1;
      else if (!req_go && resp_go)
         occ_next = occ - 1'b1;
   end

   // FIFO control and counters; req_rdy comes only from registered occupancy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occ       <= '0;
         req_rdy   <= 1'b0;
         cmd_count <= 8'd0;
         err_count <= 8'd0;
      end else begin
         if (req_go) wr_ptr <= wr_ptr + 1'b1;
         if (resp_go) rd_ptr <= rd_ptr + 1'b1;
         occ     <= occ_next;
         req_rdy <= (occ_next < DEPTH);
         if (req_go) begin
            cmd_count <= cmd_count + 8'd1;
            if (err_p0) err_count <= sat_inc8(err_count);
         end
      end
   end

   // Storage stage: payload registers carry no reset, validity lives in occ
   always_ff @(posedge clk) begin
      if (req_go) fifo_mem[wr_ptr] <= p_msg_nbits'(msg_p0);
   end

   assign resp_val = (occ != '0);
   assign resp_msg = resp_val ? fifo_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_plab5_mcore_debug_responder.sv
// Directed bench for plab5_mcore_debug_responder: vector table plus handshake,
// back-pressure, streaming and asynchronous reset sequences.
module tb_plab5_mcore_debug_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_val = 1'b0;
   logic        req_rdy;
   logic [5:0]  req_cmd = '0;
   logic        resp_val;
   logic        resp_rdy = 1'b0;
   logic [31:0] resp_msg;
   logic [63:0] core_insts = {32'h0000_0513, 32'h1234_5678};
   logic [7:0]  cmd_count;
   logic [7:0]  err_count;

   int checks = 0;
   int errors = 0;
   int exp_cmd = 0;
   int exp_err = 0;

   typedef struct {
      logic [5:0]  cmd;
      logic [31:0] msg;
      bit          err;
   } vec_t;

   vec_t vecs[8];
   vec_t good_pat[4];
   vec_t bad_pat[4];

   plab5_mcore_debug_responder #(
      .p_cmd_nbits(6), .p_msg_nbits(32), .p_num_cores(2), .p_num_entries(2)
   ) dut (
      .clk(clk), .reset(reset),
      .req_val(req_val), .req_rdy(req_rdy), .req_cmd(req_cmd),
      .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
      .core_insts(core_insts), .cmd_count(cmd_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic note_accept(input bit err);
      exp_cmd = (exp_cmd + 1) % 256;
      if (err && exp_err < 255) exp_err++;
   endtask

   task automatic check_counts(input string name);
      check({name, "_cmdcnt"}, 32'(cmd_count), 32'(exp_cmd));
      check({name, "_errcnt"}, 32'(err_count), 32'(exp_err));
   endtask

   task automatic run_stream(input int n, input bit use_bad);
      logic [31:0] q[$];
      vec_t v;
      int acc = 0;
      int pops = 0;
      int cyc = 0;
      resp_rdy = 1'b1;
      req_val  = 1'b1;
      while ((acc < n || q.size() != 0) && cyc < n + 20) begin
         v = use_bad ? bad_pat[acc % 4] : good_pat[acc % 4];
         if (acc >= n) req_val = 1'b0;
         else req_cmd = v.cmd;
         check("strm_val", 32'(resp_val), 32'(q.size() != 0));
         if (resp_val && q.size() != 0) begin
            check("strm_msg", resp_msg, q[0]);
            void'(q.pop_front());
            pops++;
         end
         if (req_val) check("strm_rdy", 32'(req_rdy), 32'd1);
         if (req_val && req_rdy) begin
            q.push_back(v.msg);
            note_accept(v.err);
            acc++;
         end
         step();
         cyc++;
      end
      check("strm_accepted", acc, n);
      check("strm_popped", pops, n);
      req_val  = 1'b0;
      resp_rdy = 1'b0;
   endtask

   initial begin
      vecs[0] = '{6'b000_001, 32'h0002_0001, 1'b0};
      vecs[1] = '{6'b000_000, 32'h0002_0000, 1'b0};
      vecs[2] = '{6'b001_001, 32'h0000_0513, 1'b0};
      vecs[3] = '{6'b001_000, 32'h1234_5678, 1'b0};
      vecs[4] = '{6'b010_000, 32'hDEAD_0010, 1'b1};
      vecs[5] = '{6'b000_101, 32'hDEAD_0005, 1'b1};
      vecs[6] = '{6'b111_111, 32'hDEAD_003F, 1'b1};
      vecs[7] = '{6'b001_010, 32'hDEAD_000A, 1'b1};
      good_pat[0] = '{6'b000_000, 32'h0002_0000, 1'b0};
      good_pat[1] = '{6'b000_001, 32'h0002_0001, 1'b0};
      good_pat[2] = '{6'b001_000, 32'h1234_5678, 1'b0};
      good_pat[3] = '{6'b001_001, 32'h0000_0513, 1'b0};
      bad_pat[0]  = '{6'b010_000, 32'hDEAD_0010, 1'b1};
      bad_pat[1]  = '{6'b011_001, 32'hDEAD_0019, 1'b1};
      bad_pat[2]  = '{6'b100_010, 32'hDEAD_0022, 1'b1};
      bad_pat[3]  = '{6'b111_111, 32'hDEAD_003F, 1'b1};

      // reset held
      #2;
      check("rst_resp_val", 32'(resp_val), 32'd0);
      check("rst_req_rdy", 32'(req_rdy), 32'd0);
      check("rst_resp_msg", resp_msg, 32'd0);
      check_counts("rst");
      step();
      check("rst_hold_rdy", 32'(req_rdy), 32'd0);
      reset = 1'b1;
      step();
      check("rel_req_rdy", 32'(req_rdy), 32'd1);
      check("rel_resp_val", 32'(resp_val), 32'd0);

      // table of single commands
      for (int i = 0; i < 8; i++) begin
         req_cmd  = vecs[i].cmd;
         req_val  = 1'b1;
         resp_rdy = 1'b0;
         check($sformatf("vec%0d_pre_val", i), 32'(resp_val), 32'd0);
         check($sformatf("vec%0d_pre_rdy", i), 32'(req_rdy), 32'd1);
         step();
         req_val = 1'b0;
         note_accept(vecs[i].err);
         check($sformatf("vec%0d_val", i), 32'(resp_val), 32'd1);
         check($sformatf("vec%0d_msg", i), resp_msg, vecs[i].msg);
         check_counts($sformatf("vec%0d", i));
         resp_rdy = 1'b1;
         step();
         resp_rdy = 1'b0;
         check($sformatf("vec%0d_drained", i), 32'(resp_val), 32'd0);
      end

      // instruction word captured in the accept cycle only
      req_cmd = 6'b001_001;
      req_val = 1'b1;
      step();
      req_val = 1'b0;
      note_accept(1'b0);
      core_insts[63:32] = 32'hFFFF_FFFF;
      step();
      check("hold_val", 32'(resp_val), 32'd1);
      check("hold_msg", resp_msg, 32'h0000_0513);
      resp_rdy = 1'b1;
      step();
      resp_rdy = 1'b0;
      core_insts[63:32] = 32'h0000_0513;

      // back-pressure: two fill the FIFO, third waits for a pop
      req_val = 1'b1;
      req_cmd = 6'b000_000;
      step();
      note_accept(1'b0);
      req_cmd = 6'b000_001;
      step();
      note_accept(1'b0);
      check("full_rdy", 32'(req_rdy), 32'd0);
      req_cmd = 6'b001_000;
      step();
      check("full_rdy_held", 32'(req_rdy), 32'd0);
      check("full_head", resp_msg, 32'h0002_0000);
      check_counts("full");
      resp_rdy = 1'b1;
      step();
      check("pop1_head", resp_msg, 32'h0002_0001);
      check("pop1_rdy", 32'(req_rdy), 32'd1);
      check_counts("pop1");
      step();
      note_accept(1'b0);
      req_val = 1'b0;
      check("pop2_val", 32'(resp_val), 32'd1);
      check("pop2_head", resp_msg, 32'h1234_5678);
      check_counts("pop2");
      step();
      check("pop3_val", 32'(resp_val), 32'd0);
      resp_rdy = 1'b0;

      // asynchronous reset with two responses buffered
      req_val = 1'b1;
      req_cmd = 6'b000_000;
      step();
      req_cmd = 6'b000_001;
      step();
      req_val = 1'b0;
      check("arst_pre_val", 32'(resp_val), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      exp_cmd = 0;
      exp_err = 0;
      check("arst_resp_val", 32'(resp_val), 32'd0);
      check("arst_resp_msg", resp_msg, 32'd0);
      check("arst_req_rdy", 32'(req_rdy), 32'd0);
      check_counts("arst");
      #3;
      reset = 1'b1;
      step();
      check("arst_rel_rdy", 32'(req_rdy), 32'd1);
      check("arst_rel_val", 32'(resp_val), 32'd0);
      req_cmd = 6'b001_000;
      req_val = 1'b1;
      step();
      req_val = 1'b0;
      note_accept(1'b0);
      check("fresh_val", 32'(resp_val), 32'd1);
      check("fresh_msg", resp_msg, 32'h1234_5678);
      check_counts("fresh");
      resp_rdy = 1'b1;
      step();
      resp_rdy = 1'b0;
      check("fresh_empty", 32'(resp_val), 32'd0);

      // streaming after a clean reset
      reset = 1'b0;
      #3;
      reset = 1'b1;
      exp_cmd = 0;
      exp_err = 0;
      step();
      run_stream(300, 1'b0);
      check("strm_cmdcnt_44", 32'(cmd_count), 32'd44);
      check_counts("strm_good");
      run_stream(300, 1'b1);
      check("strm_errcnt_sat", 32'(err_count), 32'd255);
      check_counts("strm_bad");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
